// File: rtl/wash_cycle_scheduler.sv
// Phase timer for automatic_washing_machine: generates cycle/spin timeouts.
// Optional HOLD watchdog is enabled by defining WATCHDOG_EN.
module wash_cycle_scheduler #(
    parameter int CNT_W       = 8,
    parameter int WASH_LIGHT  = 8,
    parameter int WASH_NORMAL = 16,
    parameter int WASH_HEAVY  = 32,
    parameter int RINSE_TICKS = 8,
    parameter int SPIN_TICKS  = 12,
    parameter int WD_TICKS    = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] program_sel,
    input  logic       pause,
    input  logic       soap_wash,
    input  logic       water_wash,
    input  logic       motor_on,
    input  logic       drain_value_on,
    output logic       cycle_timeout,
    output logic       spin_timeout,
    output logic [1:0] rinse_count,
    output logic       busy,
    output logic       phase_abort,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE, WASH, RINSE, SPIN, HOLD, FAULT
    } state_t;

    state_t           state, state_n;
    state_t           src, src_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       prog, prog_n;
    logic [1:0]       rc_n, rc_inc, need;
    logic             ct_n, st_n, ab_n;
    logic             w, r, s, live, hold_live;

`ifdef WATCHDOG_EN
    localparam int WD_W = $clog2(WD_TICKS + 1);
    logic [WD_W-1:0] wd, wd_n;
`endif

    assign w = soap_wash;
    assign r = water_wash;
    assign s = motor_on & drain_value_on & ~soap_wash & ~water_wash;

    assign busy  = (state == WASH) || (state == RINSE) || (state == SPIN);
    assign fault = (state == FAULT);

    assign rc_inc = (rinse_count == 2'd3) ? 2'd3 : rinse_count + 2'd1;
    assign need   = (prog == 2'b10) ? 2'd2 : 2'd1;

    function automatic logic [CNT_W-1:0] wash_ticks(input logic [1:0] p);
        case (p)
            2'b00:   return CNT_W'(WASH_LIGHT);
            2'b10:   return CNT_W'(WASH_HEAVY);
            default: return CNT_W'(WASH_NORMAL);
        endcase
    endfunction

    always_comb begin
        live = 1'b0;
        case (state)
            WASH:    live = w;
            RINSE:   live = r;
            SPIN:    live = s;
            default: live = 1'b0;
        endcase
        hold_live = 1'b0;
        case (src)
            WASH:    hold_live = w;
            RINSE:   hold_live = r;
            SPIN:    hold_live = s;
            default: hold_live = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        src_n   = src;
        cnt_n   = cnt;
        prog_n  = prog;
        rc_n    = rinse_count;
        ct_n    = cycle_timeout;
        st_n    = spin_timeout;
        ab_n    = 1'b0;
`ifdef WATCHDOG_EN
        wd_n    = wd;
`endif
        if (w && r && state != FAULT) begin
            state_n = FAULT;
            cnt_n   = '0;
            ct_n    = 1'b0;
            st_n    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (w) begin
                        prog_n  = program_sel;
                        cnt_n   = wash_ticks(program_sel);
                        rc_n    = 2'd0;
                        state_n = WASH;
                    end else if (r) begin
                        cnt_n   = CNT_W'(RINSE_TICKS);
                        state_n = RINSE;
                    end else if (s) begin
                        cnt_n   = CNT_W'(SPIN_TICKS);
                        state_n = SPIN;
                    end
                end
                WASH, RINSE, SPIN: begin
                    if (!live) begin
                        ab_n    = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else if (!pause) begin
                        if (cnt <= CNT_W'(1)) begin
                            cnt_n = '0;
                            src_n = state;
`ifdef WATCHDOG_EN
                            wd_n  = '0;
`endif
                            case (state)
                                WASH: begin
                                    ct_n    = 1'b1;
                                    state_n = HOLD;
                                end
                                RINSE: begin
                                    rc_n = rc_inc;
                                    if (rc_inc >= need) begin
                                        ct_n    = 1'b1;
                                        state_n = HOLD;
                                    end else begin
                                        cnt_n = CNT_W'(RINSE_TICKS);
                                    end
                                end
                                default: begin
                                    st_n    = 1'b1;
                                    state_n = HOLD;
                                end
                            endcase
                        end else begin
                            cnt_n = cnt - CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (!hold_live) begin
                        ct_n    = 1'b0;
                        st_n    = 1'b0;
                        state_n = IDLE;
                    end
`ifdef WATCHDOG_EN
                    else if (wd == WD_W'(WD_TICKS - 1)) begin
                        ct_n    = 1'b0;
                        st_n    = 1'b0;
                        state_n = FAULT;
                    end else begin
                        wd_n = wd + WD_W'(1);
                    end
`endif
                end
                default: state_n = FAULT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            src           <= IDLE;
            cnt           <= '0;
            prog          <= 2'b01;
            rinse_count   <= 2'd0;
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;
            phase_abort   <= 1'b0;
`ifdef WATCHDOG_EN
            wd            <= '0;
`endif
        end else begin
            state         <= state_n;
            src           <= src_n;
            cnt           <= cnt_n;
            prog          <= prog_n;
            rinse_count   <= rc_n;
            cycle_timeout <= ct_n;
            spin_timeout  <= st_n;
            phase_abort   <= ab_n;
`ifdef WATCHDOG_EN
            wd            <= wd_n;
`endif
        end
    end

endmodule

// File: tb/tb_wash_cycle_scheduler.sv
// Self-checking bench for wash_cycle_scheduler with a behavioural model.
// Directed scenarios followed by randomized phase traffic.
module tb_wash_cycle_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] program_sel = 2'b01;
    logic       pause = 1'b0;
    logic       soap_wash = 1'b0;
    logic       water_wash = 1'b0;
    logic       motor_on = 1'b0;
    logic       drain_value_on = 1'b0;
    logic       cycle_timeout, spin_timeout, busy, phase_abort, fault;
    logic [1:0] rinse_count;

    int errors = 0;
    int checks = 0;

    wash_cycle_scheduler dut (
        .clk(clk), .reset(reset), .program_sel(program_sel),
        .pause(pause), .soap_wash(soap_wash), .water_wash(water_wash),
        .motor_on(motor_on), .drain_value_on(drain_value_on),
        .cycle_timeout(cycle_timeout), .spin_timeout(spin_timeout),
        .rinse_count(rinse_count), .busy(busy),
        .phase_abort(phase_abort), .fault(fault)
    );

    always #5 clk = ~clk;

    // Model phases: 0 idle, 1 wash, 2 rinse, 3 spin, 4 hold, 5 fault.
    int m_mode = 0, m_left = 0, m_prog = 1, m_rc = 0, m_src = 0, m_wd = 0;
    bit m_ct = 0, m_st = 0, m_ab = 0;

    function automatic bit phase_on(int md, bit w, bit r, bit s);
        if (md == 1) return w;
        if (md == 2) return r;
        if (md == 3) return s;
        return 1'b0;
    endfunction

    task automatic finish_phase(int md);
        m_src  = md;
        m_mode = 4;
        m_wd   = 0;
        if (md == 3) m_st = 1'b1;
        else m_ct = 1'b1;
    endtask

    task automatic model_edge();
        bit w, r, s;
        w = soap_wash;
        r = water_wash;
        s = motor_on && drain_value_on && !w && !r;
        m_ab = 1'b0;
        if (reset) begin
            m_mode = 0; m_left = 0; m_prog = 1; m_rc = 0;
            m_ct = 0; m_st = 0; m_src = 0;
        end else if (m_mode != 5 && w && r) begin
            m_mode = 5; m_ct = 0; m_st = 0;
        end else if (m_mode == 0) begin
            if (w) begin
                m_prog = program_sel;
                m_left = (m_prog == 0) ? 8 : (m_prog == 2) ? 32 : 16;
                m_rc = 0;
                m_mode = 1;
            end else if (r) begin
                m_left = 8; m_mode = 2;
            end else if (s) begin
                m_left = 12; m_mode = 3;
            end
        end else if (m_mode >= 1 && m_mode <= 3) begin
            if (!phase_on(m_mode, w, r, s)) begin
                m_ab = 1'b1; m_left = 0; m_mode = 0;
            end else if (!pause) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (m_mode == 2) begin
                        m_rc = (m_rc + 1 > 3) ? 3 : m_rc + 1;
                        if (m_rc >= ((m_prog == 2) ? 2 : 1)) finish_phase(2);
                        else m_left = 8;
                    end else begin
                        finish_phase(m_mode);
                    end
                end
            end
        end else if (m_mode == 4) begin
            if (!phase_on(m_src, w, r, s)) begin
                m_ct = 0; m_st = 0; m_mode = 0;
            end else begin
                m_wd = m_wd + 1;
`ifdef WATCHDOG_EN
                if (m_wd >= 20) begin
                    m_mode = 5; m_ct = 0; m_st = 0;
                end
`endif
            end
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("cycle_timeout", 32'(cycle_timeout), 32'(m_ct));
        check("spin_timeout", 32'(spin_timeout), 32'(m_st));
        check("rinse_count", 32'(rinse_count), 32'(m_rc));
        check("busy", 32'(busy), 32'(m_mode >= 1 && m_mode <= 3));
        check("phase_abort", 32'(phase_abort), 32'(m_ab));
        check("fault", 32'(fault), 32'(m_mode == 5));
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    initial begin
        run(2);
        check("reset_ct", 32'(cycle_timeout), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_fault", 32'(fault), 0);
        reset = 1'b0;
        run(1);

        soap_wash = 1'b1;
        run(1);
        check("t1_busy", 32'(busy), 1);
        run(15);
        check("t1_ct_early", 32'(cycle_timeout), 0);
        run(1);
        check("t1_ct_16", 32'(cycle_timeout), 1);
        check("t1_idle_busy", 32'(busy), 0);
        soap_wash = 1'b0;
        run(1);
        check("t1_ct_clear", 32'(cycle_timeout), 0);

        program_sel = 2'b10;
        soap_wash = 1'b1;
        run(32);
        check("t2_wash_early", 32'(cycle_timeout), 0);
        run(1);
        check("t2_wash_32", 32'(cycle_timeout), 1);
        soap_wash = 1'b0;
        run(1);
        water_wash = 1'b1;
        run(9);
        check("t2_rc1", 32'(rinse_count), 1);
        check("t2_rc1_ct", 32'(cycle_timeout), 0);
        run(8);
        check("t2_rc2", 32'(rinse_count), 2);
        check("t2_rinse_ct", 32'(cycle_timeout), 1);
        water_wash = 1'b0;
        run(1);

        motor_on = 1'b1;
        drain_value_on = 1'b1;
        run(5);
        pause = 1'b1;
        run(5);
        pause = 1'b0;
        run(7);
        check("t3_spin_early", 32'(spin_timeout), 0);
        run(1);
        check("t3_spin_17", 32'(spin_timeout), 1);
        motor_on = 1'b0;
        drain_value_on = 1'b0;
        run(1);
        check("t3_spin_clear", 32'(spin_timeout), 0);

        water_wash = 1'b1;
        run(4);
        water_wash = 1'b0;
        run(1);
        check("t4_abort", 32'(phase_abort), 1);
        check("t4_busy", 32'(busy), 0);
        check("t4_ct", 32'(cycle_timeout), 0);
        run(1);
        check("t4_abort_pulse", 32'(phase_abort), 0);
        check("t4_rc_kept", 32'(rinse_count), 2);

        program_sel = 2'b00;
        soap_wash = 1'b1;
        run(9);
        check("t6_ct", 32'(cycle_timeout), 1);
        run(19);
        check("t6_no_fault_yet", 32'(fault), 0);
        run(1);
`ifdef WATCHDOG_EN
        check("t6_wd_fault", 32'(fault), 1);
`else
        check("t6_no_wd_fault", 32'(fault), 0);
        check("t6_ct_held", 32'(cycle_timeout), 1);
`endif
        soap_wash = 1'b0;
        reset = 1'b1;
        run(1);
        reset = 1'b0;

        soap_wash = 1'b1;
        water_wash = 1'b1;
        run(1);
        check("t5_fault", 32'(fault), 1);
        soap_wash = 1'b0;
        water_wash = 1'b0;
        run(3);
        check("t5_sticky", 32'(fault), 1);
        reset = 1'b1;
        run(1);
        check("t5_reset", 32'(fault), 0);
        reset = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            pause = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) program_sel = 2'($urandom);
            if ($urandom_range(0, 39) == 0) soap_wash = ~soap_wash;
            if ($urandom_range(0, 39) == 0) water_wash = ~water_wash;
            if ($urandom_range(0, 29) == 0) motor_on = ~motor_on;
            if ($urandom_range(0, 29) == 0) drain_value_on = ~drain_value_on;
            if (soap_wash && water_wash && $urandom_range(0, 19) != 0)
                water_wash = 1'b0;
            run(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
